ex_md: RTL and testbench
========================

Name: ex_md

Overview:
- Parametrised execute-stage back end that adds RV32M/RV64M multiply/divide to the EX stage and owns the EX/MEM pipeline register.
- Sits between ID/EX and MEM and takes the combinational base-ALU result as an input.
- New relative to the current EX stage:
  - XLEN generalisation.
  - Multi-cycle MUL/DIV FSM with upstream stall.
  - Downstream hold and synchronous flush.
  - Asynchronous active-low reset.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- FAST_MUL, 1: 1 = single registered product (1 iteration cycle); 0 = shift-add, XLEN iteration cycles.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_vld  in  1  ID/EX instruction valid.
- i_flush  in  1  synchronous flush of EX/MEM and FSM.
- i_hold  in  1  downstream stall: freeze EX/MEM and FSM.
- i_md  in  1  instruction is an M-extension op.
- i_md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1_rdata, i_rs2_rdata  in  XLEN  operands.
- i_alu_res  in  XLEN  base-ALU result, also the memory address.
- i_rd_waddr  in  5  destination register; i_rd_wen  in  1  destination write enable.
- i_mem_read, i_mem_write, i_mem_reg  in  1 each  memory controls.
- i_pc  in  XLEN  instruction PC; i_inst  in  32  instruction word.
- o_stall  out  1  upstream must hold ID/EX.
- o_busy  out  1  FSM not IDLE.
- o_vld  out  1  registered valid.
- o_res_ff  out  XLEN  registered result.
- o_rd_waddr  out  5; o_rd_wen  out  1.
- o_mem_read, o_mem_write, o_mem_reg  out  1 each.
- o_pc  out  XLEN; o_inst  out  32.
- o_dmem_addr  out  XLEN  = i_alu_res (combinational).
- o_dmem_wdata  out  XLEN  = i_rs2_rdata (combinational).

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - FSM goes to IDLE; all registers clear to 0.
  - o_vld=0, o_rd_wen=0, o_mem_read=0, o_mem_write=0, o_inst=32'h00000013 (NOP).
- Bubble: vld=0, rd_wen=0, mem_read=0, mem_write=0; other fields don't-care.
- FSM states: IDLE, MUL, DIV, DONE. Transitions below apply only when i_flush=0 and i_hold=0.
  - IDLE:
    - i_vld & i_md & op<4: latch operands, go to MUL.
    - i_vld & i_md & op>=4, special case (below): latch the special result, go to DONE.
    - i_vld & i_md & op>=4, otherwise: latch operand magnitudes and signs, count=XLEN, go to DIV.
  - MUL:
    - FAST_MUL=1: one cycle computing the 2*XLEN product on sign-extended XLEN+1-bit operands, then DONE.
    - FAST_MUL=0: one shift-add step per cycle for XLEN cycles, then DONE.
  - DIV:
    - Restoring, unsigned, on magnitudes; one quotient bit per cycle.
    - count decrements each cycle; the last step goes to DONE.
    - Sign fix-up on entry to DONE: quotient negated if signs differ; remainder takes the dividend sign.
  - DONE: result valid; next edge go to IDLE.
- Upstream stall: o_stall = i_hold | (i_vld & i_md & state!=DONE).
  - Stall cycles: FAST mul = 2; div = XLEN+1; special-case div = 1.
- Result select:
  - MUL: low half. MULH, MULHSU, MULHU: high half.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Div special cases, RISC-V spec:
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
- EX/MEM register, evaluated each edge in this priority:
  1. i_flush: load bubble; FSM aborts to IDLE.
  2. i_hold: all registers and FSM hold.
  3. i_md & FSM not DONE: load bubble.
  4. Otherwise load inputs. o_res_ff gets the M result if i_md, else i_alu_res; o_vld gets i_vld.
- A multi-cycle op in flight ignores input changes; operands are taken from latched copies.
- i_vld=0 never starts the FSM.
- Flush in the same cycle as DONE: the result is discarded.
- Reset mid-operation aborts with no residue.
- Counter is $clog2(XLEN)+1 bits; no wrap-around.

Decomposition:
- Package ex_md_pkg holds:
  - md_op encodings (MD_MUL..MD_REMU).
  - FSM state enum.
  - NOP_INST constant.
  - is_div/is_signed helper functions.
- Sub-module md_div holds the iterative divider datapath: remainder/quotient registers, step logic, special-case detect.
- ex_md keeps the FSM, the multiplier and the EX/MEM register.

Test Plan:
- ALU passthrough: i_vld=1, i_md=0, i_alu_res=0x00001234 -> o_vld=1, o_res_ff=0x00001234 after 1 edge; o_stall never high.
- MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
  - FAST_MUL=1: o_stall high 2 cycles, bubbles in EX/MEM meanwhile.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14.
  - o_stall high exactly 33 cycles.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - Each with 1 stall cycle.
- Flush and reset:
  - i_flush at DIV iteration 10 -> next cycle FSM IDLE, o_vld=0; a following MUL 3*4 -> 12.
  - i_rst_n low mid-DIV -> outputs reset immediately, without waiting for a clock edge.
- Hold: i_hold=1 for 3 cycles while in DONE -> o_res_ff/o_vld unchanged, FSM stays DONE; on release the result is registered once.

Source files
------------

// File: rtl/ex_md_pkg.sv
// rtl/ex_md_pkg.sv - shared encodings and helpers for the EX-stage M-extension back end
package ex_md_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Signedness of rs1: the dividend for DIV/REM, the multiplicand for MULH/MULHSU.
  function automatic logic is_signed(input logic [2:0] op);
    return op[2] ? ~op[0] : ((op == MD_MULH) || (op == MD_MULHSU));
  endfunction

endpackage

// File: rtl/md_div.sv
// rtl/md_div.sv - restoring divider on operand magnitudes, one quotient bit per step
module md_div
  import ex_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            sgn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic            last,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] q_r, r_r, b_mag_r;
  logic            neg_q, neg_r;
  logic [CW-1:0]   cnt;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, spec_q, spec_r;
  logic [XLEN:0]   r_sh, diff;

  always_comb begin
    a_neg   = sgn & a[XLEN-1];
    b_neg   = sgn & b[XLEN-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    special = (b == '0) | (sgn & (a == MOST_NEG) & (b == '1));
    spec_q  = (b == '0) ? '1 : a;
    spec_r  = (b == '0) ? a : '0;
    r_sh    = {r_r, q_r[XLEN-1]};
    diff    = r_sh - {1'b0, b_mag_r};
    last    = (cnt == CW'(1));
    quo     = neg_q ? -q_r : q_r;
    rem     = neg_r ? -r_r : r_r;
  end

  // Special cases park their final values here with the sign flags cleared,
  // so the result path is identical for every divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= '0;
      r_r     <= '0;
      b_mag_r <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      if (special) begin
        q_r   <= spec_q;
        r_r   <= spec_r;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
        cnt   <= '0;
      end else begin
        q_r     <= a_mag;
        r_r     <= '0;
        b_mag_r <= b_mag;
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        cnt     <= CW'(XLEN);
      end
    end else if (step) begin
      cnt <= cnt - CW'(1);
      if (!diff[XLEN]) begin
        r_r <= diff[XLEN-1:0];
        q_r <= {q_r[XLEN-2:0], 1'b1};
      end else begin
        r_r <= r_sh[XLEN-1:0];
        q_r <= {q_r[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_md.sv
// rtl/ex_md.sv - EX-stage back end: RV M-extension FSM, multiplier and EX/MEM register
module ex_md
  import ex_md_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_vld,
  input  logic            i_flush,
  input  logic            i_hold,
  input  logic            i_md,
  input  logic [2:0]      i_md_op,
  input  logic [XLEN-1:0] i_rs1_rdata,
  input  logic [XLEN-1:0] i_rs2_rdata,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic [4:0]      i_rd_waddr,
  input  logic            i_rd_wen,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic            i_mem_reg,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_vld,
  output logic [XLEN-1:0] o_res_ff,
  output logic [4:0]      o_rd_waddr,
  output logic            o_rd_wen,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_mem_reg,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata
);

  localparam int CW = $clog2(XLEN) + 1;

  state_e            state, state_n;
  logic              mul_load, mul_step, div_load, div_step;
  logic              div_special, div_last;
  logic [XLEN-1:0]   div_quo, div_rem, md_res;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] prod, ma_sh, acc_n;
  logic [XLEN:0]     mb_sh;
  logic [CW-1:0]     mul_cnt;
  logic              rs1_sgn, rs2_sgn;
  logic signed [2*XLEN+1:0] prod_fast;

  assign o_dmem_addr  = i_alu_res;
  assign o_dmem_wdata = i_rs2_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    mul_load = 1'b0;
    mul_step = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    o_stall  = i_hold | (i_vld & i_md & (state != S_DONE));
    o_busy   = (state != S_IDLE);
    if (i_flush) begin
      state_n = S_IDLE;
    end else if (!i_hold) begin
      case (state)
        S_IDLE: if (i_vld && i_md) begin
          if (is_div(i_md_op)) begin
            div_load = 1'b1;
            state_n  = div_special ? S_DONE : S_DIV;
          end else begin
            mul_load = 1'b1;
            state_n  = S_MUL;
          end
        end
        S_MUL: begin
          mul_step = 1'b1;
          if (FAST_MUL != 0 || mul_cnt == CW'(1)) state_n = S_DONE;
        end
        S_DIV: begin
          div_step = 1'b1;
          if (div_last) state_n = S_DONE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  md_div #(.XLEN(XLEN)) u_div (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (div_load),
    .step    (div_step),
    .sgn     (is_signed(i_md_op)),
    .a       (i_rs1_rdata),
    .b       (i_rs2_rdata),
    .special (div_special),
    .last    (div_last),
    .quo     (div_quo),
    .rem     (div_rem)
  );

  // Operands are sign/zero extended to XLEN+1 bits so one signed product covers all four ops.
  // The serial path treats mb_sh bit XLEN as a negative weight and subtracts it on the last step.
  always_comb begin
    rs1_sgn   = is_signed(i_md_op);
    rs2_sgn   = (i_md_op == MD_MULH);
    prod_fast = $signed(ma_sh[XLEN:0]) * $signed(mb_sh);
    acc_n     = prod + (mb_sh[0] ? ma_sh : '0)
              - (((mul_cnt == CW'(1)) && mb_sh[1]) ? (ma_sh << 1) : '0);
    if (is_div(op_q))         md_res = op_q[1] ? div_rem : div_quo;
    else if (op_q == MD_MUL)  md_res = prod[XLEN-1:0];
    else                      md_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q    <= '0;
      prod    <= '0;
      ma_sh   <= '0;
      mb_sh   <= '0;
      mul_cnt <= '0;
    end else if (mul_load) begin
      op_q    <= i_md_op;
      prod    <= '0;
      ma_sh   <= {{XLEN{rs1_sgn & i_rs1_rdata[XLEN-1]}}, i_rs1_rdata};
      mb_sh   <= {rs2_sgn & i_rs2_rdata[XLEN-1], i_rs2_rdata};
      mul_cnt <= CW'(XLEN);
    end else if (div_load) begin
      op_q <= i_md_op;
    end else if (mul_step) begin
      if (FAST_MUL != 0) begin
        prod <= prod_fast[2*XLEN-1:0];
      end else begin
        prod    <= acc_n;
        ma_sh   <= ma_sh << 1;
        mb_sh   <= mb_sh >> 1;
        mul_cnt <= mul_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vld       <= 1'b0;
      o_res_ff    <= '0;
      o_rd_waddr  <= '0;
      o_rd_wen    <= 1'b0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_reg   <= 1'b0;
      o_pc        <= '0;
      o_inst      <= NOP_INST;
    end else if (i_flush || (!i_hold && i_md && state != S_DONE)) begin
      o_vld       <= 1'b0;
      o_rd_wen    <= 1'b0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
    end else if (!i_hold) begin
      o_vld       <= i_vld;
      o_res_ff    <= i_md ? md_res : i_alu_res;
      o_rd_waddr  <= i_rd_waddr;
      o_rd_wen    <= i_rd_wen;
      o_mem_read  <= i_mem_read;
      o_mem_write <= i_mem_write;
      o_mem_reg   <= i_mem_reg;
      o_pc        <= i_pc;
      o_inst      <= i_inst;
    end
  end

endmodule

// File: tb/tb_ex_md.sv
// tb/tb_ex_md.sv - directed self-checking bench for ex_md (XLEN=32, FAST_MUL=1)
module tb_ex_md;

  logic        i_clk, i_rst_n, i_vld, i_flush, i_hold, i_md;
  logic [2:0]  i_md_op;
  logic [31:0] i_rs1_rdata, i_rs2_rdata, i_alu_res, i_pc, i_inst;
  logic [4:0]  i_rd_waddr;
  logic        i_rd_wen, i_mem_read, i_mem_write, i_mem_reg;
  logic        o_stall, o_busy, o_vld, o_rd_wen, o_mem_read, o_mem_write, o_mem_reg;
  logic [31:0] o_res_ff, o_pc, o_inst, o_dmem_addr, o_dmem_wdata;
  logic [4:0]  o_rd_waddr;

  int n_checks = 0;
  int n_errors = 0;

  ex_md #(.XLEN(32), .FAST_MUL(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .i_flush(i_flush), .i_hold(i_hold),
    .i_md(i_md), .i_md_op(i_md_op), .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
    .i_alu_res(i_alu_res), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_reg(i_mem_reg),
    .i_pc(i_pc), .i_inst(i_inst), .o_stall(o_stall), .o_busy(o_busy), .o_vld(o_vld),
    .o_res_ff(o_res_ff), .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_reg(o_mem_reg),
    .o_pc(o_pc), .o_inst(o_inst), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_vld = 1'b1; i_md = 1'b1; i_md_op = op;
    i_rs1_rdata = a; i_rs2_rdata = b; i_rd_wen = 1'b1;
    #1;
  endtask

  task automatic idle_inputs();
    i_vld = 1'b0; i_md = 1'b0; i_rd_wen = 1'b0; i_mem_read = 1'b0;
  endtask

  // Counts stall cycles up to the DONE state, then lets the result register.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int  stalls = 0;
    bit  bubbles = 1'b1;
    issue(op, a, b);
    while (o_stall && stalls < 100) begin
      stalls++;
      tick();
      if (o_vld !== 1'b0) bubbles = 1'b0;
    end
    tick();
    check({tag, " res"}, o_res_ff, exp);
    check({tag, " vld"}, o_vld, 1);
    check({tag, " stalls"}, stalls, exp_stall);
    check({tag, " bubbles"}, bubbles, 1);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_hold = 1'b0; i_vld = 1'b0; i_md = 1'b0;
    i_md_op = 3'd0; i_rs1_rdata = '0; i_rs2_rdata = '0; i_alu_res = '0;
    i_rd_waddr = 5'd0; i_rd_wen = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_mem_reg = 1'b0; i_pc = '0; i_inst = 32'h00000013;
    tick(); tick();
    check("rst vld", o_vld, 0);
    check("rst inst", o_inst, 32'h00000013);
    check("rst busy", o_busy, 0);
    check("rst rd_wen", o_rd_wen, 0);
    check("rst mem_read", o_mem_read, 0);
    i_rst_n = 1'b1;
    tick();

    i_vld = 1'b1; i_alu_res = 32'h00001234; i_rs2_rdata = 32'h55; i_inst = 32'hDEADBEEF;
    i_pc = 32'h100; i_rd_waddr = 5'd5; i_rd_wen = 1'b1; i_mem_read = 1'b1;
    #1;
    check("alu stall", o_stall, 0);
    check("alu dmem_addr", o_dmem_addr, 32'h1234);
    check("alu dmem_wdata", o_dmem_wdata, 32'h55);
    tick();
    check("alu vld", o_vld, 1);
    check("alu res", o_res_ff, 32'h1234);
    check("alu inst", o_inst, 32'hDEADBEEF);
    check("alu pc", o_pc, 32'h100);
    check("alu mem_read", o_mem_read, 1);
    check("alu rd_waddr", o_rd_waddr, 5);
    check("alu stall after", o_stall, 0);
    idle_inputs();
    tick();

    run_md("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
    run_md("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 2);
    run_md("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    run_md("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2);
    run_md("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_md("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_md("divu",   3'd5, 32'd100,      32'd7,        32'd14,       33);
    run_md("remu",   3'd7, 32'd100,      32'd7,        32'd2,        33);
    run_md("divu0",  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_md("remu0",  3'd7, 32'd5,        32'd0,        32'd5,        1);
    run_md("divov",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_md("remov",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    issue(3'd5, 32'd100, 32'd7);
    for (int i = 0; i < 40 && o_stall; i++) tick();
    check("hold reach done", o_stall, 0);
    i_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold vld", o_vld, 0);
      check("hold busy", o_busy, 1);
    end
    i_hold = 1'b0;
    tick();
    check("hold release res", o_res_ff, 32'd14);
    check("hold release vld", o_vld, 1);
    idle_inputs();
    tick();
    check("hold once", o_vld, 0);

    issue(3'd5, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    check("flush busy before", o_busy, 1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    idle_inputs();
    check("flush busy", o_busy, 0);
    check("flush vld", o_vld, 0);
    tick();
    run_md("mul after flush", 3'd0, 32'd3, 32'd4, 32'd12, 2);

    issue(3'd0, 32'd3, 32'd5);
    tick(); tick();
    check("done flush stall", o_stall, 0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    idle_inputs();
    check("done flush vld", o_vld, 0);
    check("done flush busy", o_busy, 0);
    tick();

    i_vld = 1'b1; i_alu_res = 32'h00000ABC; i_inst = 32'hDEADBEEF; i_pc = 32'h200;
    tick();
    issue(3'd4, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    check("pre-rst busy", o_busy, 1);
    check("pre-rst inst", o_inst, 32'hDEADBEEF);
    idle_inputs();
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async rst busy", o_busy, 0);
    check("async rst res", o_res_ff, 0);
    check("async rst inst", o_inst, 32'h00000013);
    check("async rst pc", o_pc, 0);
    i_rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
